// File: rtl/risc_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit RISC core.
// Drives imem fetch, register-file addressing, ALU opcode and write-back select.
module risc_control_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [1:0]      rf_ra,
  output logic [1:0]      rf_rb,
  output logic            rf_we,
  output logic [1:0]      rf_waddr,
  output logic            wb_sel,
  output logic [7:0]      imm,
  output logic [1:0]      alu_op,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc_out,
  output logic            z_flag
);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK
  } state_t;

  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_JZ  = 2'b11;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [7:0]      ir, ir_nx;
  logic            z, z_nx;
  logic [1:0]      op;
  logic            is_alu;

  assign op     = ir[7:6];
  assign is_alu = ~op[1];

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign z_flag    = z;
  assign rf_ra     = ir[5:4];
  assign rf_rb     = ir[3:2];
  assign rf_waddr  = ir[5:4];
  assign imm       = {4'b0000, ir[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      z     <= z_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    z_nx     = z;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = 2'b00;
    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nx    = imem_rdata;
          pc_nx    = pc + PC_W'(1);
          state_nx = DECODE;
        end
      end
      DECODE: begin
        state_nx = EXECUTE;
      end
      EXECUTE: begin
        if (is_alu) begin
          alu_op = op;
          z_nx   = alu_zero;
        end
        if (op == OP_JZ) begin
          if (z) pc_nx = PC_W'(ir[5:0]);
          state_nx = FETCH;
        end else begin
          state_nx = WRITEBACK;
        end
      end
      WRITEBACK: begin
        rf_we    = 1'b1;
        wb_sel   = (op == OP_LDI);
        if (is_alu) alu_op = op;
        state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
    // Reset wins over any in-flight request or write.
    if (rst) begin
      imem_req = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      alu_op   = 2'b00;
    end
  end

endmodule
